// File: rtl/satvsmt_pkg.sv
// Shared constants and elaboration helpers for the satvsmt flip-flop pipeline.
// Widths, set/reset value and parameter legality are all derived here.
package satvsmt_pkg;

  function automatic bit regset_legal(string regset);
    return (regset == "SET") || (regset == "RESET");
  endfunction

  function automatic bit width_legal(int width);
    return (width >= 1) && (width <= 64);
  endfunction

  function automatic bit depth_legal(int depth);
    return (depth >= 1) && (depth <= 16);
  endfunction

  // Value loaded by LSR and at power-up: all-ones for "SET", all-zeros for "RESET".
  function automatic logic [63:0] srval(string regset, int width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (regset == "SET") ? mask : 64'd0;
  endfunction

  function automatic int tapw(int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int fillw(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/satvsmt_ff_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit, with
// synchronous LSR taking priority over the clock enable.
module satvsmt_ff_stage
  import satvsmt_pkg::*;
#(
  parameter int    WIDTH  = 8,
  parameter string REGSET = "SET"
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             V,
  output logic [WIDTH-1:0] Q,
  output logic             VQ
);

  localparam logic [WIDTH-1:0] SRVAL = WIDTH'(srval(REGSET, WIDTH));

  // Power-up contents match the post-LSR state.
  logic [WIDTH-1:0] data_q = SRVAL;
  logic [WIDTH-1:0] data_d;
  logic             valid_q = 1'b0;
  logic             valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (CE) begin
      data_d  = D;
      valid_d = V;
    end
  end

  always_ff @(posedge CLK) begin
    if (LSR) begin
      data_q  <= SRVAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Q  = data_q;
  assign VQ = valid_q;

endmodule

// File: rtl/satvsmt_ff_pipe.sv
// DEPTH-stage enabled shift pipeline with valid tracking, a saturating fill
// counter and a combinational tap onto any stage.
module satvsmt_ff_pipe
  import satvsmt_pkg::*;
#(
  parameter int    WIDTH  = 8,
  parameter int    DEPTH  = 4,
  parameter string REGSET = "SET",
  localparam int   TAPW   = tapw(DEPTH),
  localparam int   FILLW  = fillw(DEPTH)
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic             CE,
  input  logic [WIDTH-1:0] DI,
  input  logic             VI,
  input  logic [TAPW-1:0]  TAP,
  output logic [WIDTH-1:0] Q,
  output logic             VO,
  output logic [WIDTH-1:0] QTAP,
  output logic             VTAP,
  output logic [FILLW-1:0] FILL,
  output logic             PRIMED
);

  localparam logic [WIDTH-1:0] SRVAL = WIDTH'(srval(REGSET, WIDTH));

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("satvsmt_ff_pipe: WIDTH must be 1..64");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("satvsmt_ff_pipe: DEPTH must be 1..16");
  end
  if (!regset_legal(REGSET)) begin : g_bad_regset
    $error("satvsmt_ff_pipe: REGSET must be \"SET\" or \"RESET\"");
  end

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    if (i == 0) begin : g_head
      assign d_in = DI;
      assign v_in = VI;
    end else begin : g_body
      assign d_in = stage_data[i-1];
      assign v_in = stage_valid[i-1];
    end
    satvsmt_ff_stage #(
      .WIDTH  (WIDTH),
      .REGSET (REGSET)
    ) u_stage (
      .CLK (CLK),
      .LSR (LSR),
      .CE  (CE),
      .D   (d_in),
      .V   (v_in),
      .Q   (stage_data[i]),
      .VQ  (stage_valid[i])
    );
  end

  assign Q  = stage_data[DEPTH-1];
  assign VO = stage_valid[DEPTH-1];

  // Counts enabled shifts since the last LSR, holding once the pipe is full.
  logic [FILLW-1:0] fill_q = '0;
  logic [FILLW-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (CE && (fill_q != FILLW'(DEPTH))) begin
      fill_d = fill_q + FILLW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (LSR) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign FILL   = fill_q;
  assign PRIMED = (fill_q == FILLW'(DEPTH));

  if (DEPTH == 1) begin : g_tap_single
    logic unused_tap;
    assign unused_tap = ^TAP;
    assign QTAP = stage_data[0];
    assign VTAP = stage_valid[0];
  end else begin : g_tap_mux
    // Indices past the last stage read back the idle (srval, invalid) value.
    always_comb begin
      QTAP = SRVAL;
      VTAP = 1'b0;
      if (int'(TAP) < DEPTH) begin
        QTAP = stage_data[TAP];
        VTAP = stage_valid[TAP];
      end
    end
  end

endmodule

// File: tb/tb_satvsmt_ff_pipe.sv
// Bench for satvsmt_ff_pipe: three configurations (8x4 SET, 8x5 RESET, 1x1 SET)
// driven in lockstep and compared against a queue-based pipeline model.
module tb_satvsmt_ff_pipe;

  logic       CLK = 1'b0;
  logic       lsr, ce, vi;
  logic [7:0] di;
  logic [1:0] tap_a;
  logic [2:0] tap_b;
  logic       tap_c;

  logic [7:0] q_a, qtap_a;
  logic       vo_a, vtap_a, primed_a;
  logic [2:0] fill_a;
  logic [7:0] q_b, qtap_b;
  logic       vo_b, vtap_b, primed_b;
  logic [2:0] fill_b;
  logic       q_c, qtap_c, vo_c, vtap_c, primed_c;
  logic       fill_c;

  always #5 CLK = ~CLK;

  satvsmt_ff_pipe #(.WIDTH(8), .DEPTH(4), .REGSET("SET")) dut_a (
    .CLK(CLK), .LSR(lsr), .CE(ce), .DI(di), .VI(vi), .TAP(tap_a),
    .Q(q_a), .VO(vo_a), .QTAP(qtap_a), .VTAP(vtap_a), .FILL(fill_a), .PRIMED(primed_a)
  );

  satvsmt_ff_pipe #(.WIDTH(8), .DEPTH(5), .REGSET("RESET")) dut_b (
    .CLK(CLK), .LSR(lsr), .CE(ce), .DI(di), .VI(vi), .TAP(tap_b),
    .Q(q_b), .VO(vo_b), .QTAP(qtap_b), .VTAP(vtap_b), .FILL(fill_b), .PRIMED(primed_b)
  );

  satvsmt_ff_pipe #(.WIDTH(1), .DEPTH(1), .REGSET("SET")) dut_c (
    .CLK(CLK), .LSR(lsr), .CE(ce), .DI(di[0]), .VI(vi), .TAP(tap_c),
    .Q(q_c), .VO(vo_c), .QTAP(qtap_c), .VTAP(vtap_c), .FILL(fill_c), .PRIMED(primed_c)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          dep  [3] = '{4, 5, 1};
  logic [63:0] srv  [3] = '{64'hFF, 64'h00, 64'h1};
  logic [63:0] mask [3] = '{64'hFF, 64'hFF, 64'h1};
  int          fill_m [3];
  // Model stage k contents: element 0 is stage 0, element DEPTH-1 drives Q.
  logic [64:0] mq [3][$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    mq[k].delete();
    for (int i = 0; i < dep[k]; i++) mq[k].push_back({1'b0, srv[k]});
    fill_m[k] = 0;
  endtask

  task automatic model_edge(int k, logic l, logic c, logic [7:0] d, logic v);
    if (l) begin
      model_reset(k);
    end else if (c) begin
      mq[k].push_front({v, 64'(d) & mask[k]});
      void'(mq[k].pop_back());
      if (fill_m[k] < dep[k]) fill_m[k]++;
    end
  endtask

  function automatic logic [64:0] exp_tap(int k, int t);
    if (dep[k] == 1) return mq[k][0];
    if (t < dep[k]) return mq[k][t];
    return {1'b0, srv[k]};
  endfunction

  task automatic check_outputs();
    logic [64:0] e;
    e = mq[0][dep[0]-1];
    check("a_q", 64'(q_a), e[63:0]);
    check("a_vo", 64'(vo_a), 64'(e[64]));
    check("a_fill", 64'(fill_a), 64'(fill_m[0]));
    check("a_primed", 64'(primed_a), 64'(fill_m[0] == dep[0]));
    e = exp_tap(0, int'(tap_a));
    check("a_qtap", 64'(qtap_a), e[63:0]);
    check("a_vtap", 64'(vtap_a), 64'(e[64]));
    e = mq[1][dep[1]-1];
    check("b_q", 64'(q_b), e[63:0]);
    check("b_vo", 64'(vo_b), 64'(e[64]));
    check("b_fill", 64'(fill_b), 64'(fill_m[1]));
    check("b_primed", 64'(primed_b), 64'(fill_m[1] == dep[1]));
    e = exp_tap(1, int'(tap_b));
    check("b_qtap", 64'(qtap_b), e[63:0]);
    check("b_vtap", 64'(vtap_b), 64'(e[64]));
    e = mq[2][0];
    check("c_q", 64'(q_c), e[63:0]);
    check("c_vo", 64'(vo_c), 64'(e[64]));
    check("c_fill", 64'(fill_c), 64'(fill_m[2]));
    check("c_primed", 64'(primed_c), 64'(fill_m[2] == dep[2]));
    e = exp_tap(2, int'(tap_c));
    check("c_qtap", 64'(qtap_c), e[63:0]);
    check("c_vtap", 64'(vtap_c), 64'(e[64]));
  endtask

  task automatic step(logic l, logic c, logic [7:0] d, logic v);
    lsr = l; ce = c; di = d; vi = v;
    tap_a = 2'($urandom); tap_b = 3'($urandom); tap_c = 1'($urandom);
    @(posedge CLK);
    for (int k = 0; k < 3; k++) model_edge(k, l, c, d, v);
    @(negedge CLK);
    check_outputs();
  endtask

  initial begin
    lsr = 1'b0; ce = 1'b0; di = 8'h00; vi = 1'b0;
    tap_a = 2'd0; tap_b = 3'd0; tap_c = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);

    // Power-up state equals the post-LSR state without any reset edge.
    #1;
    check_outputs();

    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_q", 64'(q_a), 64'hFF);
    for (int t = 0; t < 4; t++) begin
      tap_a = 2'(t);
      #1;
      check("rst_qtap", 64'(qtap_a), 64'hFF);
    end

    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
    check("lat_q", 64'(q_a), 64'h01);
    check("lat_vo", 64'(vo_a), 64'h1);
    check("lat_fill", 64'(fill_a), 64'd4);
    step(1'b0, 1'b1, 8'h05, 1'b1);
    check("lat_sat", 64'(fill_a), 64'd4);

    step(1'b1, 1'b1, 8'h55, 1'b1);
    check("mid_rst_q", 64'(q_a), 64'hFF);
    check("mid_rst_fill", 64'(fill_a), 64'd0);

    step(1'b0, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 8'hAA : 8'h55, 1'b1);
    check("stall_fill", 64'(fill_a), 64'd2);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    check("stall_q", 64'(q_a), 64'h11);

    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b1);
    tap_b = 3'd0; #1; check("tap0", 64'(qtap_b), 64'hA4);
    tap_b = 3'd4; #1; check("tap4", 64'(qtap_b), 64'hA0);
    tap_b = 3'd7; #1; check("tap7", 64'(qtap_b), 64'h00);
    check("tap7_v", 64'(vtap_b), 64'h0);

    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'(i % 2), 1'b1);
      check("deg_q", 64'(q_c), 64'(i % 2));
      check("deg_fill", 64'(fill_c), 64'd1);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 16) == 0, ($urandom % 4) != 0, 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
